mod_counter_seq: RTL and testbench

- Sequencer for a programmable mod-N up counter in the counters/dividers library.
- Accepts a configuration (modulus, repeat count) over a valid/ready handshake.
- Runs the counter for the requested number of full wraps and emits a terminal-count tick each wrap, then a done pulse.
- Serves as the synchronous, controllable replacement for free-running mod counters when a divider must run for a bounded number of periods.

---
 rtl/mod_counter_seq_pkg.sv | 12 +
 rtl/mod_counter_seq_if.sv | 26 ++
 rtl/mod_counter_seq_cnt.sv | 35 +++
 rtl/mod_counter_seq.sv | 114 +++++++++++
 tb/tb_mod_counter_seq.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/mod_counter_seq_pkg.sv
// Shared types and constants for the mod-N counter sequencer.
package mod_counter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int MIN_MOD = 2;

endpackage

// File: rtl/mod_counter_seq_if.sv
// Configuration handshake and status bundle of the mod-N counter sequencer.
interface mod_counter_seq_if #(
    parameter int CNT_W = 4,
    parameter int REP_W = 8
);
    logic             cfg_valid_i;
    logic             cfg_ready_o;
    logic [CNT_W-1:0] cfg_mod_i;
    logic [REP_W-1:0] cfg_reps_i;
    logic             abort_i;
    logic [CNT_W-1:0] q_o;
    logic             tick_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;

    modport slave (
        input  cfg_valid_i, cfg_mod_i, cfg_reps_i, abort_i,
        output cfg_ready_o, q_o, tick_o, busy_o, done_o, err_o
    );

    modport master (
        output cfg_valid_i, cfg_mod_i, cfg_reps_i, abort_i,
        input  cfg_ready_o, q_o, tick_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/mod_counter_seq_cnt.sv
// Mod-N count register: clears on clr, otherwise counts 0..mod-1 while enabled.
module mod_n_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] mod,
    output logic [CNT_W-1:0] q,
    output logic             tc
);
    logic [CNT_W-1:0] q_q;
    logic [CNT_W-1:0] q_d;

    assign tc = (q_q == mod - CNT_W'(1));
    assign q  = q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = tc ? '0 : q_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end
endmodule

// File: rtl/mod_counter_seq.sv
// Sequencer that runs a mod-N counter for a configured number of wraps,
// ticking on every wrap and pulsing done on normal completion.
module mod_counter_seq
    import mod_counter_seq_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int REP_W = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    mod_counter_seq_if.slave bus
);
    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] mod_q, mod_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic [REP_W-1:0] rem_q, rem_d;
    logic             err_q, err_d;

    logic             cnt_en;
    logic             cnt_clr;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt_q;
    logic             tick;
    logic             done;

    mod_n_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .mod   (mod_q),
        .q     (cnt_q),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        mod_d   = mod_q;
        reps_d  = reps_q;
        rem_d   = rem_q;
        err_d   = 1'b0;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        tick    = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // abort has no meaning here, so a request is always honoured
                if (bus.cfg_valid_i) begin
                    if (bus.cfg_mod_i < CNT_W'(MIN_MOD)) begin
                        err_d = 1'b1;
                    end else begin
                        mod_d   = bus.cfg_mod_i;
                        reps_d  = bus.cfg_reps_i;
                        rem_d   = bus.cfg_reps_i;
                        cnt_clr = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.abort_i) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_tc) begin
                        tick = 1'b1;
                        // reps==0 runs forever; remaining count never underflows
                        if (reps_q != '0) begin
                            if (rem_q <= REP_W'(1)) begin
                                state_d = DONE;
                            end
                            if (rem_q != '0) begin
                                rem_d = rem_q - REP_W'(1);
                            end
                        end
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mod_q   <= '0;
            reps_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mod_q   <= mod_d;
            reps_q  <= reps_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    assign bus.cfg_ready_o = (state_q == IDLE);
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.q_o         = cnt_q;
    assign bus.tick_o      = tick;
    assign bus.done_o      = done;
    assign bus.err_o       = err_q;
endmodule

// File: tb/tb_mod_counter_seq.sv
// Directed self-checking bench for mod_counter_seq.
module tb_mod_counter_seq;
    localparam int CNT_W = 4;
    localparam int REP_W = 8;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    mod_counter_seq_if #(.CNT_W(CNT_W), .REP_W(REP_W)) bus ();

    mod_counter_seq #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // q, tick, done, busy, ready checked together
    task automatic chk_out(input string tag, input int q, input int tick,
                           input int done, input int busy, input int ready);
        chk({tag, ".q"},     int'(bus.q_o),         q);
        chk({tag, ".tick"},  int'(bus.tick_o),      tick);
        chk({tag, ".done"},  int'(bus.done_o),      done);
        chk({tag, ".busy"},  int'(bus.busy_o),      busy);
        chk({tag, ".ready"}, int'(bus.cfg_ready_o), ready);
    endtask

    task automatic send(input int m, input int r);
        bus.cfg_valid_i = 1'b1;
        bus.cfg_mod_i   = CNT_W'(m);
        bus.cfg_reps_i  = REP_W'(r);
        cyc();
        bus.cfg_valid_i = 1'b0;
    endtask

    initial begin
        bus.cfg_valid_i = 1'b0;
        bus.cfg_mod_i   = '0;
        bus.cfg_reps_i  = '0;
        bus.abort_i     = 1'b0;

        // Reset for two cycles, then idle
        rst_i = 1'b1;
        cyc();
        cyc();
        chk_out("rst", 0, 0, 0, 0, 1);
        chk("rst.err", int'(bus.err_o), 0);
        rst_i = 1'b0;
        cyc();
        chk_out("idle0", 0, 0, 0, 0, 1);
        chk("idle0.err", int'(bus.err_o), 0);

        // N=10, R=2
        send(10, 2);
        for (int k = 1; k <= 22; k++) begin
            if (k <= 20)
                chk_out($sformatf("n10.k%0d", k), (k - 1) % 10, (k % 10 == 0) ? 1 : 0, 0, 1, 0);
            else if (k == 21)
                chk_out("n10.done", 0, 0, 1, 1, 0);
            else
                chk_out("n10.idle", 0, 0, 0, 0, 1);
            if (k < 22) cyc();
        end

        // Illegal modulus 1, then N=2, R=1
        send(1, 3);
        chk("ill.err", int'(bus.err_o), 1);
        chk_out("ill", 0, 0, 0, 0, 1);
        cyc();
        chk("ill.err_end", int'(bus.err_o), 0);
        send(2, 1);
        chk_out("n2.k1", 0, 0, 0, 1, 0);
        cyc();
        chk_out("n2.k2", 1, 1, 0, 1, 0);
        cyc();
        chk_out("n2.k3", 0, 0, 1, 1, 0);
        cyc();
        chk_out("n2.k4", 0, 0, 0, 0, 1);

        // N=5, R=0, abort in the third tick cycle
        send(5, 0);
        for (int k = 1; k <= 15; k++) begin
            if (k == 15) begin
                bus.abort_i = 1'b1;
                #1;
                chk_out("n5.abort", 4, 0, 0, 1, 0);
            end else begin
                chk_out($sformatf("n5.k%0d", k), (k - 1) % 5, (k % 5 == 0) ? 1 : 0, 0, 1, 0);
                cyc();
            end
        end
        cyc();
        bus.abort_i = 1'b0;
        chk_out("n5.after", 0, 0, 0, 0, 1);
        cyc();
        chk_out("n5.after2", 0, 0, 0, 0, 1);

        // cfg_valid held through an N=4, R=1 run; abort in DONE ignored
        bus.cfg_valid_i = 1'b1;
        bus.cfg_mod_i   = 4'd4;
        bus.cfg_reps_i  = 8'd1;
        cyc();
        for (int k = 1; k <= 6; k++) begin
            if (k == 5) begin
                bus.abort_i = 1'b1;
                #1;
                chk_out("hold.done", 0, 0, 1, 1, 0);
            end else if (k == 6) begin
                bus.abort_i    = 1'b0;
                bus.cfg_mod_i  = 4'd3;
                bus.cfg_reps_i = 8'd1;
                #1;
                chk_out("hold.idle", 0, 0, 0, 0, 1);
            end else begin
                chk_out($sformatf("hold.k%0d", k), k - 1, (k == 4) ? 1 : 0, 0, 1, 0);
            end
            cyc();
        end
        bus.cfg_valid_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k <= 3) chk_out($sformatf("n3.k%0d", k), k - 1, (k == 3) ? 1 : 0, 0, 1, 0);
            else        chk_out("n3.done", 0, 0, 1, 1, 0);
            cyc();
        end
        chk_out("n3.idle", 0, 0, 0, 0, 1);

        // N=15, R=1, reset mid-run at q=7
        send(15, 1);
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("n15.q%0d", k), int'(bus.q_o), k - 1);
            if (k < 8) cyc();
        end
        rst_i = 1'b1;
        #1;
        chk("n15.rst_tick", int'(bus.tick_o), 0);
        cyc();
        rst_i = 1'b0;
        chk_out("n15.rst", 0, 0, 0, 0, 1);
        cyc();
        chk_out("n15.rst2", 0, 0, 0, 0, 1);

        // N=15 full wrap: 14 -> 0; abort with cfg_valid in IDLE still accepts
        bus.abort_i = 1'b1;
        send(15, 1);
        bus.abort_i = 1'b0;
        chk_out("n15b.k1", 0, 0, 0, 1, 0);
        for (int k = 2; k <= 16; k++) begin
            cyc();
            if (k <= 15) chk_out($sformatf("n15b.k%0d", k), k - 1, (k == 15) ? 1 : 0, 0, 1, 0);
            else         chk_out("n15b.done", 0, 0, 1, 1, 0);
        end
        cyc();
        chk_out("n15b.idle", 0, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
